// File: rtl/sim_harness_pkg.sv
// Shared types and defaults for the simulation/self-test run controller.
package sim_harness_pkg;

  typedef enum logic [2:0] {IDLE, HOLD, RUN, PASS, FAIL} seq_state_t;

  localparam int DEF_RESET_CYCLES   = 10;
  localparam int DEF_TIMEOUT_CYCLES = 10000;

  // Index width for a channel vector; a single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_prio_enc.sv
// Lowest-set-bit priority encoder: index of the first asserted request plus a valid flag.
module sim_prio_enc #(
  parameter int N     = 1,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sim_test_sequencer.sv
// Run controller: timed DUT reset, monitors N testbench channels, reports PASS/FAIL/TIMEOUT.
module sim_test_sequencer
  import sim_harness_pkg::*;
#(
  parameter int N_CHANNELS     = 1,
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int AUTO_START     = 1,
  parameter int REQUIRE_ALL    = 1,
  parameter int CNT_W          = 32
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [N_CHANNELS-1:0]                chan_success,
  input  logic [N_CHANNELS-1:0]                chan_fail,
  output logic                                 dut_reset,
  output logic                                 running,
  output logic                                 done,
  output logic                                 pass,
  output logic                                 fail,
  output logic                                 timeout,
  output logic [idx_width(N_CHANNELS)-1:0]     fail_chan,
  output logic [N_CHANNELS-1:0]                success_mask,
  output logic [CNT_W-1:0]                     cycle_count
);

  localparam int               IDX_W       = idx_width(N_CHANNELS);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam seq_state_t       RESET_STATE = (AUTO_START != 0) ? HOLD : IDLE;

  seq_state_t             state_q, state_d;
  logic [CNT_W-1:0]       phase_q, phase_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [N_CHANNELS-1:0]  mask_q, mask_d;
  logic [IDX_W-1:0]       fail_chan_q, fail_chan_d;
  logic                   timeout_q, timeout_d;
  logic                   dut_reset_q, dut_reset_d;
  logic                   running_q, running_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic                   fail_q, fail_d;

  logic [N_CHANNELS-1:0]  mask_run;
  logic                   all_ok;
  logic [IDX_W-1:0]       fail_idx, miss_idx;
  logic                   fail_vld, miss_vld;

  assign mask_run = mask_q | chan_success;
  assign all_ok   = (REQUIRE_ALL != 0) ? (&mask_run) : (|mask_run);

  sim_prio_enc #(.N(N_CHANNELS), .IDX_W(IDX_W)) u_fail_enc (
    .req (chan_fail),
    .idx (fail_idx),
    .vld (fail_vld)
  );

  // Timeout blames the first channel still missing, including this cycle's successes.
  sim_prio_enc #(.N(N_CHANNELS), .IDX_W(IDX_W)) u_miss_enc (
    .req (~mask_run),
    .idx (miss_idx),
    .vld (miss_vld)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    count_d     = count_q;
    mask_d      = mask_q;
    fail_chan_d = fail_chan_q;
    timeout_d   = timeout_q;
    case (state_q)
      IDLE, PASS, FAIL: begin
        if (start) begin
          state_d     = HOLD;
          phase_d     = '0;
          count_d     = '0;
          mask_d      = '0;
          fail_chan_d = '0;
          timeout_d   = 1'b0;
        end
      end
      HOLD: begin
        if (phase_q == HOLD_LAST) begin
          state_d = RUN;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      RUN: begin
        count_d = (&count_q) ? count_q : count_q + 1'b1;
        mask_d  = mask_run;
        if (fail_vld) begin
          state_d     = FAIL;
          fail_chan_d = fail_idx;
        end else if (all_ok) begin
          state_d = PASS;
        end else if ((TIMEOUT_CYCLES != 0) && (count_q == TO_LAST)) begin
          state_d     = FAIL;
          timeout_d   = 1'b1;
          fail_chan_d = ((REQUIRE_ALL != 0) && miss_vld) ? miss_idx : '0;
        end
      end
      default: state_d = RESET_STATE;
    endcase

    // Flags are registered from the next state so they change with the state itself.
    dut_reset_d = (state_d == IDLE) || (state_d == HOLD);
    running_d   = (state_d == RUN);
    pass_d      = (state_d == PASS);
    fail_d      = (state_d == FAIL);
    done_d      = pass_d || fail_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RESET_STATE;
      phase_q     <= '0;
      count_q     <= '0;
      mask_q      <= '0;
      fail_chan_q <= '0;
      timeout_q   <= 1'b0;
      dut_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      count_q     <= count_d;
      mask_q      <= mask_d;
      fail_chan_q <= fail_chan_d;
      timeout_q   <= timeout_d;
      dut_reset_q <= dut_reset_d;
      running_q   <= running_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

  assign dut_reset    = dut_reset_q;
  assign running      = running_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign timeout      = timeout_q;
  assign fail_chan    = fail_chan_q;
  assign success_mask = mask_q;
  assign cycle_count  = count_q;

endmodule
